// File: rtl/arm_pkg.sv
// Shared types and constants for the 5-stage ARM core pipeline.
// Holds operand widths, EXE_CMD encodings and the ID/EXE bundle.
package arm_pkg;

   localparam int DATA_W = 32;
   localparam int REG_W  = 4;
   localparam int CMD_W  = 4;

   // ALU commands; several opcodes share an ALU op
   localparam logic [CMD_W-1:0] EXE_MOV = 4'b0001;
   localparam logic [CMD_W-1:0] EXE_MVN = 4'b1001;
   localparam logic [CMD_W-1:0] EXE_ADD = 4'b0010;
   localparam logic [CMD_W-1:0] EXE_ADC = 4'b0011;
   localparam logic [CMD_W-1:0] EXE_SUB = 4'b0100;
   localparam logic [CMD_W-1:0] EXE_SBC = 4'b0101;
   localparam logic [CMD_W-1:0] EXE_AND = 4'b0110;
   localparam logic [CMD_W-1:0] EXE_ORR = 4'b0111;
   localparam logic [CMD_W-1:0] EXE_EOR = 4'b1000;
   localparam logic [CMD_W-1:0] EXE_CMP = 4'b0100;
   localparam logic [CMD_W-1:0] EXE_TST = 4'b0110;
   localparam logic [CMD_W-1:0] EXE_LDR = 4'b0010;
   localparam logic [CMD_W-1:0] EXE_STR = 4'b0010;

   typedef struct packed {
      logic              wb_en;
      logic              mem_r_en;
      logic              mem_w_en;
      logic              b;
      logic              s;
      logic [CMD_W-1:0]  exe_cmd;
      logic [DATA_W-1:0] val_rn;
      logic [DATA_W-1:0] val_rm;
      logic              immediate;
      logic [11:0]       shifter_operand;
      logic [23:0]       signed_imm_24;
      logic [REG_W-1:0]  dest;
      logic [REG_W-1:0]  src1;
      logic [REG_W-1:0]  src2;
      logic [DATA_W-1:0] pc;
      logic              c;
   } id_exe_t;

endpackage

// File: rtl/pipe_reg.sv
// Generic stage register: async active-low reset, enable, sync clear.
// Ports: clk, rst, en (hold when 0), clr (zero on enabled edge), d, q.
module pipe_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         clr,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         q <= '0;
      else if (en)
         q <= clr ? '0 : d;
   end

endmodule

// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register with freeze (hold) over flush (squash).
// Ports: clk, rst, freeze, flush, decoded *_in fields -> registered fields, valid.
module id_exe_reg
   import arm_pkg::*;
#(
   parameter int DATA_W = arm_pkg::DATA_W,
   parameter int REG_W  = arm_pkg::REG_W,
   parameter int CMD_W  = arm_pkg::CMD_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              freeze,
   input  logic              flush,
   input  logic              WB_EN_in,
   input  logic              MEM_R_EN_in,
   input  logic              MEM_W_EN_in,
   input  logic              B_in,
   input  logic              S_in,
   input  logic [CMD_W-1:0]  EXE_CMD_in,
   input  logic [DATA_W-1:0] Val_Rn_in,
   input  logic [DATA_W-1:0] Val_Rm_in,
   input  logic              immediate_in,
   input  logic [11:0]       shifter_operand_in,
   input  logic [23:0]       Signed_immediate_24_in,
   input  logic [REG_W-1:0]  Dest_in,
   input  logic [REG_W-1:0]  src1_in,
   input  logic [REG_W-1:0]  src2_in,
   input  logic [DATA_W-1:0] PC_in,
   input  logic              C_in,
   output logic              WB_EN,
   output logic              MEM_R_EN,
   output logic              MEM_W_EN,
   output logic              B,
   output logic              S,
   output logic [CMD_W-1:0]  EXE_CMD,
   output logic [DATA_W-1:0] Val_Rn,
   output logic [DATA_W-1:0] Val_Rm,
   output logic              immediate,
   output logic [11:0]       shifter_operand,
   output logic [23:0]       Signed_immediate_24,
   output logic [REG_W-1:0]  Dest,
   output logic [REG_W-1:0]  src1,
   output logic [REG_W-1:0]  src2,
   output logic [DATA_W-1:0] PC,
   output logic              C,
   output logic              valid
);

   localparam int ENTRY_W = $bits(id_exe_t) + 1;

   id_exe_t            d_bus;
   id_exe_t            q_bus;
   logic [ENTRY_W-1:0] q_raw;

   always_comb begin
      d_bus                 = '0;
      d_bus.wb_en           = WB_EN_in;
      d_bus.mem_r_en        = MEM_R_EN_in;
      d_bus.mem_w_en        = MEM_W_EN_in;
      d_bus.b               = B_in;
      d_bus.s               = S_in;
      d_bus.exe_cmd         = EXE_CMD_in;
      d_bus.val_rn          = Val_Rn_in;
      d_bus.val_rm          = Val_Rm_in;
      d_bus.immediate       = immediate_in;
      d_bus.shifter_operand = shifter_operand_in;
      d_bus.signed_imm_24   = Signed_immediate_24_in;
      d_bus.dest            = Dest_in;
      d_bus.src1            = src1_in;
      d_bus.src2            = src2_in;
      d_bus.pc              = PC_in;
      d_bus.c               = C_in;
   end

   // valid rides along as the top bit: a load writes 1,
   // while clear and reset zero it with the rest of the entry.
   pipe_reg #(
      .W (ENTRY_W)
   ) u_reg (
      .clk (clk),
      .rst (rst),
      .en  (~freeze),
      .clr (flush & ~freeze),
      .d   ({1'b1, d_bus}),
      .q   (q_raw)
   );

   assign {valid, q_bus} = q_raw;

   assign WB_EN               = q_bus.wb_en;
   assign MEM_R_EN            = q_bus.mem_r_en;
   assign MEM_W_EN            = q_bus.mem_w_en;
   assign B                   = q_bus.b;
   assign S                   = q_bus.s;
   assign EXE_CMD             = q_bus.exe_cmd;
   assign Val_Rn              = q_bus.val_rn;
   assign Val_Rm              = q_bus.val_rm;
   assign immediate           = q_bus.immediate;
   assign shifter_operand     = q_bus.shifter_operand;
   assign Signed_immediate_24 = q_bus.signed_imm_24;
   assign Dest                = q_bus.dest;
   assign src1                = q_bus.src1;
   assign src2                = q_bus.src2;
   assign PC                  = q_bus.pc;
   assign C                   = q_bus.c;

endmodule

// File: tb/tb_id_exe_reg.sv
// Self-checking bench for id_exe_reg: directed vectors plus a
// per-cycle comparison against a rule-level model of the entry.
module tb_id_exe_reg;

   logic        clk = 1'b0;
   logic        rst;
   logic        freeze;
   logic        flush;
   logic        WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, B_in, S_in;
   logic [3:0]  EXE_CMD_in;
   logic [31:0] Val_Rn_in, Val_Rm_in;
   logic        immediate_in;
   logic [11:0] shifter_operand_in;
   logic [23:0] Signed_immediate_24_in;
   logic [3:0]  Dest_in, src1_in, src2_in;
   logic [31:0] PC_in;
   logic        C_in;

   logic        WB_EN, MEM_R_EN, MEM_W_EN, B, S;
   logic [3:0]  EXE_CMD;
   logic [31:0] Val_Rn, Val_Rm;
   logic        immediate;
   logic [11:0] shifter_operand;
   logic [23:0] Signed_immediate_24;
   logic [3:0]  Dest, src1, src2;
   logic [31:0] PC;
   logic        C;
   logic        valid;

   id_exe_reg dut (
      .clk                    (clk),
      .rst                    (rst),
      .freeze                 (freeze),
      .flush                  (flush),
      .WB_EN_in               (WB_EN_in),
      .MEM_R_EN_in            (MEM_R_EN_in),
      .MEM_W_EN_in            (MEM_W_EN_in),
      .B_in                   (B_in),
      .S_in                   (S_in),
      .EXE_CMD_in             (EXE_CMD_in),
      .Val_Rn_in              (Val_Rn_in),
      .Val_Rm_in              (Val_Rm_in),
      .immediate_in           (immediate_in),
      .shifter_operand_in     (shifter_operand_in),
      .Signed_immediate_24_in (Signed_immediate_24_in),
      .Dest_in                (Dest_in),
      .src1_in                (src1_in),
      .src2_in                (src2_in),
      .PC_in                  (PC_in),
      .C_in                   (C_in),
      .WB_EN                  (WB_EN),
      .MEM_R_EN               (MEM_R_EN),
      .MEM_W_EN               (MEM_W_EN),
      .B                      (B),
      .S                      (S),
      .EXE_CMD                (EXE_CMD),
      .Val_Rn                 (Val_Rn),
      .Val_Rm                 (Val_Rm),
      .immediate              (immediate),
      .shifter_operand        (shifter_operand),
      .Signed_immediate_24    (Signed_immediate_24),
      .Dest                   (Dest),
      .src1                   (src1),
      .src2                   (src2),
      .PC                     (PC),
      .C                      (C),
      .valid                  (valid)
   );

   always #5 clk = ~clk;

   wire [154:0] in_vec = {WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, B_in, S_in,
      EXE_CMD_in, Val_Rn_in, Val_Rm_in, immediate_in, shifter_operand_in,
      Signed_immediate_24_in, Dest_in, src1_in, src2_in, PC_in, C_in};
   wire [154:0] out_vec = {WB_EN, MEM_R_EN, MEM_W_EN, B, S,
      EXE_CMD, Val_Rn, Val_Rm, immediate, shifter_operand,
      Signed_immediate_24, Dest, src1, src2, PC, C};

   logic [154:0] exp_vec;
   logic         exp_valid;
   int           n_chk = 0;
   int           n_fail = 0;

   task automatic chk(input string name, input logic [255:0] act,
                      input logic [255:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("entry", {101'd0, out_vec}, {101'd0, exp_vec});
      chk("valid", {255'd0, valid}, {255'd0, exp_valid});
   end

   task automatic set_in(input logic [154:0] v);
      {WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, B_in, S_in,
       EXE_CMD_in, Val_Rn_in, Val_Rm_in, immediate_in, shifter_operand_in,
       Signed_immediate_24_in, Dest_in, src1_in, src2_in, PC_in, C_in} = v;
   endtask

   task automatic set_rand();
      logic [159:0] r;
      r = {$urandom, $urandom, $urandom, $urandom, $urandom};
      set_in(r[154:0]);
   endtask

   // Model: the entry seen by EXE follows reset > freeze > flush > load.
   task automatic step(input logic fz, input logic fl);
      freeze = fz;
      flush  = fl;
      @(posedge clk);
      if (!rst) begin
         exp_vec   = '0;
         exp_valid = 1'b0;
      end else if (fz) begin
         exp_vec   = exp_vec;
      end else if (fl) begin
         exp_vec   = '0;
         exp_valid = 1'b0;
      end else begin
         exp_vec   = in_vec;
         exp_valid = 1'b1;
      end
      #2;
   endtask

   initial begin
      exp_vec   = '0;
      exp_valid = 1'b0;
      freeze    = 1'b0;
      flush     = 1'b0;
      rst       = 1'b0;
      set_in({155{1'b1}});
      #1;
      chk("rst_entry", {101'd0, out_vec}, 256'd0);
      chk("rst_valid", {255'd0, valid}, 256'd0);
      #1 rst = 1'b1;

      // first edge after release loads
      set_in({155{1'b1}});
      step(1'b0, 1'b0);
      chk("rel_valid", {255'd0, valid}, 256'd1);
      chk("rel_pc", {224'd0, PC}, {224'd0, 32'hFFFF_FFFF});

      // directed load
      set_in('0);
      Val_Rn_in  = 32'hDEAD_BEEF;
      EXE_CMD_in = 4'b0010;
      Dest_in    = 4'd5;
      WB_EN_in   = 1'b1;
      step(1'b0, 1'b0);
      chk("ld_rn", {224'd0, Val_Rn}, {224'd0, 32'hDEAD_BEEF});
      chk("ld_cmd", {252'd0, EXE_CMD}, 256'd2);
      chk("ld_dest", {252'd0, Dest}, 256'd5);
      chk("ld_wb", {255'd0, WB_EN}, 256'd1);
      chk("ld_rm", {224'd0, Val_Rm}, 256'd0);

      // flush squashes new inputs, next edge loads them
      set_in('0);
      WB_EN_in    = 1'b1;
      MEM_W_EN_in = 1'b1;
      Val_Rm_in   = 32'h0000_00A5;
      step(1'b0, 1'b1);
      chk("fl_wb", {255'd0, WB_EN}, 256'd0);
      chk("fl_memw", {255'd0, MEM_W_EN}, 256'd0);
      chk("fl_valid", {255'd0, valid}, 256'd0);
      step(1'b0, 1'b0);
      chk("fl_next_memw", {255'd0, MEM_W_EN}, 256'd1);
      chk("fl_next_rm", {224'd0, Val_Rm}, 256'hA5);

      // freeze for 3 cycles with toggling inputs
      set_in('0);
      Val_Rn_in = 32'hDEAD_BEEF;
      step(1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         set_rand();
         step(1'b1, 1'b0);
         chk("fz_hold_rn", {224'd0, Val_Rn}, {224'd0, 32'hDEAD_BEEF});
      end
      set_in('0);
      Val_Rn_in = 32'h1234_5678;
      step(1'b0, 1'b0);
      chk("fz_rel_rn", {224'd0, Val_Rn}, {224'd0, 32'h1234_5678});

      // freeze + flush holds, then flush alone clears
      for (int i = 0; i < 2; i++) begin
         set_rand();
         step(1'b1, 1'b1);
         chk("ff_hold_valid", {255'd0, valid}, 256'd1);
         chk("ff_hold_rn", {224'd0, Val_Rn}, {224'd0, 32'h1234_5678});
      end
      step(1'b0, 1'b1);
      chk("ff_clr_valid", {255'd0, valid}, 256'd0);
      chk("ff_clr_rn", {224'd0, Val_Rn}, 256'd0);

      // a zeroed bubble from ID still counts as valid
      set_in('0);
      step(1'b0, 1'b0);
      chk("bubble_valid", {255'd0, valid}, 256'd1);

      // async reset pulse while frozen
      set_rand();
      Val_Rn_in = 32'hCAFE_F00D;
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      rst       = 1'b0;
      exp_vec   = '0;
      exp_valid = 1'b0;
      #1;
      chk("arst_rn", {224'd0, Val_Rn}, 256'd0);
      chk("arst_valid", {255'd0, valid}, 256'd0);
      #1 rst = 1'b1;
      set_rand();
      step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      chk("arst_stay", {101'd0, out_vec}, 256'd0);
      step(1'b0, 1'b0);
      chk("arst_load_valid", {255'd0, valid}, 256'd1);

      // random mix checked by the per-cycle compare
      for (int i = 0; i < 40; i++) begin
         set_rand();
         step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
      end

      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
